// File: rtl/intersect_driver.sv
// Ray-triangle intersection driver.
// For one ray, it streams triangles 0..N-1 from triangle memory into the
// pipelined intersection unit. It then reduces the in-order hit results to
// the closest hit.
module intersect_driver #(
    parameter int                 IDX_W  = 16,
    parameter logic signed [31:0] T_INIT = 32'sh7fffffff
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_start,
    input  logic signed [31:0]       i_ray [2][3],
    input  logic [IDX_W-1:0]         i_num_tri,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_hit,
    output logic signed [31:0]       o_t,
    output logic [IDX_W-1:0]         o_tri_idx,
    output logic                     o_tri_rd,
    output logic [IDX_W-1:0]         o_tri_addr,
    input  logic                     i_tri_gnt,
    input  logic                     i_tri_rvalid,
    input  logic signed [31:0]       i_tri [3][3],
    output logic                     o_isect_en,
    output logic signed [31:0]       o_isect_tri [3][3],
    output logic signed [31:0]       o_isect_ray [2][3],
    input  logic signed [31:0]       i_isect_t,
    input  logic                     i_isect_result,
    input  logic                     i_isect_valid
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [IDX_W-1:0]   num;
    logic [IDX_W-1:0]   req_cnt;
    logic [IDX_W-1:0]   fwd_cnt;
    logic [IDX_W-1:0]   ret_cnt;
    logic               hit;
    logic signed [31:0] best_t;
    logic [IDX_W-1:0]   best_idx;

    logic               fwd_acc;
    logic               ret_acc;
    logic               last_ret;
    logic               upd;
    logic [IDX_W-1:0]   ret_inc;
    logic               nxt_hit;
    logic signed [31:0] nxt_t;
    logic [IDX_W-1:0]   nxt_idx;

    // A strictly closer hit replaces the best one, so ties keep the earlier index.
    function automatic logic is_closer(input logic result,
                                       input logic signed [31:0] t,
                                       input logic signed [31:0] best);
        return result && (t < best);
    endfunction

    // Accept strobes and the candidate best-hit values, including the current return.
    always_comb begin
        fwd_acc  = (state == RUN) && i_tri_rvalid && (fwd_cnt < num);
        ret_acc  = (state == RUN) && i_isect_valid;
        ret_inc  = ret_cnt + IDX_W'(1);
        last_ret = ret_acc && (ret_inc == num);
        upd      = ret_acc && is_closer(i_isect_result, i_isect_t, best_t);
        nxt_hit  = hit | upd;
        nxt_t    = upd ? i_isect_t : best_t;
        nxt_idx  = upd ? ret_cnt : best_idx;
    end

    assign o_busy     = (state == RUN);
    assign o_tri_rd   = (state == RUN) && (req_cnt < num);
    assign o_tri_addr = req_cnt;

    // Control FSM: request counting, result reduction, and registered done and result outputs.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state     <= IDLE;
            num       <= '0;
            req_cnt   <= '0;
            fwd_cnt   <= '0;
            ret_cnt   <= '0;
            hit       <= 1'b0;
            best_t    <= T_INIT;
            best_idx  <= '0;
            o_done    <= 1'b0;
            o_hit     <= 1'b0;
            o_t       <= T_INIT;
            o_tri_idx <= '0;
            for (int a = 0; a < 2; a++)
                for (int b = 0; b < 3; b++)
                    o_isect_ray[a][b] <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        o_isect_ray <= i_ray;
                        num         <= i_num_tri;
                        req_cnt     <= '0;
                        fwd_cnt     <= '0;
                        ret_cnt     <= '0;
                        hit         <= 1'b0;
                        best_t      <= T_INIT;
                        best_idx    <= '0;
                        if (i_num_tri == '0) begin
                            state     <= DONE;
                            o_done    <= 1'b1;
                            o_hit     <= 1'b0;
                            o_t       <= T_INIT;
                            o_tri_idx <= '0;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (o_tri_rd && i_tri_gnt)
                        req_cnt <= req_cnt + IDX_W'(1);
                    if (fwd_acc)
                        fwd_cnt <= fwd_cnt + IDX_W'(1);
                    if (ret_acc) begin
                        ret_cnt  <= ret_inc;
                        hit      <= nxt_hit;
                        best_t   <= nxt_t;
                        best_idx <= nxt_idx;
                    end
                    if (last_ret) begin
                        state     <= DONE;
                        o_done    <= 1'b1;
                        o_hit     <= nxt_hit;
                        o_t       <= nxt_t;
                        o_tri_idx <= nxt_idx;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Forward stage: register returned triangle data into the intersection unit.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_isect_en <= 1'b0;
            for (int a = 0; a < 3; a++)
                for (int b = 0; b < 3; b++)
                    o_isect_tri[a][b] <= '0;
        end else begin
            o_isect_en <= fwd_acc;
            if (fwd_acc)
                o_isect_tri <= i_tri;
        end
    end

endmodule
